// File: rtl/qspi_psram_model_q.sv
// -----------------------------------------------------------------------------
// qspi_psram_model_q
//
// Parametrised QPI PSRAM slave model for simulation tops. It oversamples sck
// and ce_n on the model clock and decodes quad-wide command, address, wait and
// data phases. It serves a byte-wide backing array named `ram`, which can be
// preloaded hierarchically by the enclosing simulation top.
//
// Commands:
//   0xEB  quad read     : cmd, 24-bit addr, WAIT_CYC wait rises, read data
//   0x38  quad write    : cmd, 24-bit addr, write data
//   0x9F  read ID       : cmd, dummy addr, WAIT_CYC wait rises, DEV_ID bytes
//   other               : ignored until ce_n rises
//
// Parameters:
//   ADR_W      byte address width (5..24); array holds 2^ADR_W bytes
//   WAIT_CYC   sck rises between the last address nibble and the first read
//              nibble (0..15)
//   DEV_ID     two ID bytes, high byte first, repeating
//   PAGE_BYTES wrap page size (power of two, <= 2^ADR_W)
//
// Ports:
//   clk     in   model clock, at least 4x the sck frequency
//   rst     in   synchronous active-high reset
//   sck     in   QSPI serial clock from the controller
//   ce_n    in   chip enable, active low
//   sio_i   in   sampled quad data lines
//   sio_o   out  driven read data nibble
//   sio_oe  out  output enable for sio_o
//   active  out  high while the state is not IDLE
//
// Compile option:
//   QSPI_PSRAM_PAGE_WRAP_EN  when defined, burst address increments wrap
//                            inside the PAGE_BYTES-aligned page; otherwise
//                            they wrap only at 2^ADR_W.
// -----------------------------------------------------------------------------
module qspi_psram_model_q #(
  parameter int          ADR_W      = 16,
  parameter int          WAIT_CYC   = 6,
  parameter logic [15:0] DEV_ID     = 16'h0D5D,
  parameter int          PAGE_BYTES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] sio_i,
  output logic [3:0] sio_o,
  output logic       sio_oe,
  output logic       active
);

  if (((PAGE_BYTES & (PAGE_BYTES - 1)) != 0) || (PAGE_BYTES > (1 << ADR_W)))
  begin : g_bad_page
    $error("PAGE_BYTES must be a power of two no larger than 2^ADR_W");
  end

  localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYC == 0) ? 0 : (WAIT_CYC - 1));

`ifdef QSPI_PSRAM_PAGE_WRAP_EN
  localparam logic [ADR_W-1:0] PAGE_MASK = ADR_W'(PAGE_BYTES - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_RDATA,
    ST_WDATA,
    ST_IDRD,
    ST_IGNORE
  } state_t;

  logic [7:0] ram [0:(1 << ADR_W) - 1];

  state_t           state;
  logic [3:0]       cnt;
  logic             hi_sel;   // 1: next data nibble is the low nibble
  logic             id_sel;   // 1: next ID byte is DEV_ID[7:0]
  logic [ADR_W-1:0] addr;
  logic [3:0]       cmd_hi;
  logic             cmd_wr;
  logic             cmd_id;
  logic [3:0]       wbuf;
  logic             armed;    // ce_n has been seen high since reset

  // Burst address increment.
  function automatic logic [ADR_W-1:0] next_addr(input logic [ADR_W-1:0] a);
`ifdef QSPI_PSRAM_PAGE_WRAP_EN
    next_addr = (a & ~PAGE_MASK) | ((a + 1'b1) & PAGE_MASK);
`else
    next_addr = a + 1'b1;
`endif
  endfunction

  // Stage p0/p1: two-flop synchronisers; p2: previous synchronised sample.
  // These track the pins continuously and carry no reset, so the true ce_n
  // level is known immediately after a reset.
  logic sck_p0, sck_p1, sck_p2;
  logic ce_n_p0, ce_n_p1, ce_n_p2;

  always_ff @(posedge clk) begin
    sck_p0  <= sck;
    sck_p1  <= sck_p0;
    sck_p2  <= sck_p1;
    ce_n_p0 <= ce_n;
    ce_n_p1 <= ce_n_p0;
    ce_n_p2 <= ce_n_p1;
  end

  logic ce_hi, ce_fall, sck_rise, sck_fall;

  // sck edges are masked while ce_n is high, so a simultaneous ce_n rise
  // always wins over an sck rise.
  assign ce_hi    = ce_n_p1;
  assign ce_fall  = !ce_n_p1 && ce_n_p2;
  assign sck_rise = !ce_hi && sck_p1 && !sck_p2;
  assign sck_fall = !ce_hi && !sck_p1 && sck_p2;

  logic [7:0] cur_byte;

  always_comb begin
    cur_byte = ram[addr];
    if (state == ST_IDRD) begin
      cur_byte = id_sel ? DEV_ID[7:0] : DEV_ID[15:8];
    end
  end

  // A write byte commits on the rise that carries its low nibble.
  logic wr_en;
  assign wr_en = !rst && (state == ST_WDATA) && sck_rise && hi_sel;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[addr] <= {wbuf, sio_i};
    end
  end

  // Stage p3: transaction FSM acting on the synchronised edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      sio_o  <= 4'h0;
      sio_oe <= 1'b0;
      active <= 1'b0;
      cnt    <= 4'h0;
      hi_sel <= 1'b0;
      id_sel <= 1'b0;
      addr   <= '0;
      cmd_hi <= 4'h0;
      cmd_wr <= 1'b0;
      cmd_id <= 1'b0;
      wbuf   <= 4'h0;
      armed  <= 1'b0;
    end else if (ce_hi) begin
      // Deselect: abort whatever is in flight; a lone write nibble in wbuf
      // is simply never committed.
      armed  <= 1'b1;
      state  <= ST_IDLE;
      sio_oe <= 1'b0;
      active <= 1'b0;
      cnt    <= 4'h0;
      hi_sel <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!armed) begin
            // ce_n was already low when reset released: sit out this
            // transaction rather than decode it from the middle.
            state  <= ST_IGNORE;
            active <= 1'b1;
          end else if (ce_fall) begin
            state  <= ST_CMD;
            active <= 1'b1;
            cnt    <= 4'h0;
            hi_sel <= 1'b0;
            id_sel <= 1'b0;
          end
        end

        ST_CMD: begin
          if (sck_rise) begin
            if (cnt == 4'h0) begin
              cmd_hi <= sio_i;
              cnt    <= 4'h1;
            end else begin
              cnt <= 4'h0;
              case ({cmd_hi, sio_i})
                8'hEB: begin
                  state  <= ST_ADDR;
                  cmd_wr <= 1'b0;
                  cmd_id <= 1'b0;
                end
                8'h38: begin
                  state  <= ST_ADDR;
                  cmd_wr <= 1'b1;
                  cmd_id <= 1'b0;
                end
                8'h9F: begin
                  state  <= ST_ADDR;
                  cmd_wr <= 1'b0;
                  cmd_id <= 1'b1;
                end
                default: state <= ST_IGNORE;
              endcase
            end
          end
        end

        ST_ADDR: begin
          if (sck_rise) begin
            // Shifting through an ADR_W-wide register drops the address
            // bits above ADR_W on their own.
            addr <= {addr[ADR_W-5:0], sio_i};
            if (cnt == 4'h5) begin
              cnt <= 4'h0;
              if (cmd_wr) begin
                state <= ST_WDATA;
              end else if (WAIT_CYC == 0) begin
                state <= cmd_id ? ST_IDRD : ST_RDATA;
              end else begin
                state <= ST_WAIT;
              end
            end else begin
              cnt <= cnt + 4'h1;
            end
          end
        end

        ST_WAIT: begin
          if (sck_rise) begin
            if (cnt == WAIT_LAST) begin
              cnt   <= 4'h0;
              state <= cmd_id ? ST_IDRD : ST_RDATA;
            end else begin
              cnt <= cnt + 4'h1;
            end
          end
        end

        ST_RDATA, ST_IDRD: begin
          if (sck_fall) begin
            sio_oe <= 1'b1;
            sio_o  <= hi_sel ? cur_byte[3:0] : cur_byte[7:4];
            hi_sel <= !hi_sel;
            if (hi_sel) begin
              if (state == ST_RDATA) begin
                addr <= next_addr(addr);
              end else begin
                id_sel <= !id_sel;
              end
            end
          end
        end

        ST_WDATA: begin
          if (sck_rise) begin
            if (!hi_sel) begin
              wbuf   <= sio_i;
              hi_sel <= 1'b1;
            end else begin
              hi_sel <= 1'b0;
              addr   <= next_addr(addr);
            end
          end
        end

        ST_IGNORE: begin
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_psram_model_q.sv
// -----------------------------------------------------------------------------
// tb_qspi_psram_model_q
//
// Directed bench for qspi_psram_model_q. sck runs at 1/8 of clk (4 clk low,
// 4 clk high). Inputs change on the falling edge of clk and outputs are
// sampled on the falling edge of clk.
// -----------------------------------------------------------------------------
module tb_qspi_psram_model_q;

  localparam int WAIT_CYC = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       ce_n;
  logic [3:0] sio_i;
  logic [3:0] sio_o;
  logic       sio_oe;
  logic       active;

  int total = 0;
  int bad   = 0;

  qspi_psram_model_q #(
    .ADR_W     (16),
    .WAIT_CYC  (WAIT_CYC),
    .DEV_ID    (16'h0D5D),
    .PAGE_BYTES(1024)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sck   (sck),
    .ce_n  (ce_n),
    .sio_i (sio_i),
    .sio_o (sio_o),
    .sio_oe(sio_oe),
    .active(active)
  );

  always #5 clk = ~clk;

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sck period carrying a nibble into the model; ends with sck low.
  task automatic send_nib(input logic [3:0] n);
    sio_i = n;
    clks(4);
    sck = 1'b1;
    clks(4);
    sck = 1'b0;
  endtask

  // One sck period reading the nibble driven at the preceding fall.
  task automatic read_nib(output logic [3:0] n, output logic oe);
    clks(4);
    n  = sio_o;
    oe = sio_oe;
    sck = 1'b1;
    clks(4);
    sck = 1'b0;
  endtask

  task automatic read_byte(output logic [7:0] b, output logic oe);
    logic [3:0] hi, lo;
    logic       oe_hi, oe_lo;
    read_nib(hi, oe_hi);
    read_nib(lo, oe_lo);
    b  = {hi, lo};
    oe = oe_hi & oe_lo;
  endtask

  task automatic ce_low();
    ce_n = 1'b0;
    clks(4);
  endtask

  task automatic ce_high();
    sck   = 1'b0;
    sio_i = 4'h0;
    clks(2);
    ce_n = 1'b1;
    clks(6);
  endtask

  task automatic send_cmd_addr(input logic [7:0] cmd, input logic [23:0] a);
    send_nib(cmd[7:4]);
    send_nib(cmd[3:0]);
    for (int i = 5; i >= 0; i--) begin
      send_nib(a[4*i +: 4]);
    end
  endtask

  task automatic send_wait(input int n);
    for (int i = 0; i < n; i++) begin
      send_nib(4'h0);
    end
  endtask

  task automatic write_byte_at(input logic [23:0] a, input logic [7:0] d);
    ce_low();
    send_cmd_addr(8'h38, a);
    send_nib(d[7:4]);
    send_nib(d[3:0]);
    ce_high();
  endtask

  logic [7:0] b;
  logic [3:0] nib;
  logic       oe;

  initial begin
    rst   = 1'b1;
    sck   = 1'b0;
    ce_n  = 1'b1;
    sio_i = 4'h0;
    clks(4);
    rst = 1'b0;
    clks(2);
    chk("rst_sio_oe", 32'(sio_oe), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_sio_o", 32'(sio_o), 32'h0);

    // Preload 0x10..0x13 with one burst write.
    ce_low();
    chk("active_after_fall", 32'(active), 32'h1);
    send_cmd_addr(8'h38, 24'h000010);
    send_nib(4'h1); send_nib(4'h1);
    send_nib(4'h2); send_nib(4'h2);
    send_nib(4'h3); send_nib(4'h3);
    send_nib(4'h4); send_nib(4'h4);
    ce_high();
    chk("active_after_rise", 32'(active), 32'h0);

    // Quad read of 4 bytes at 0x10, checked nibble by nibble.
    ce_low();
    send_cmd_addr(8'hEB, 24'h000010);
    chk("oe_after_addr", 32'(sio_oe), 32'h0);
    send_wait(WAIT_CYC - 1);
    chk("oe_in_wait", 32'(sio_oe), 32'h0);
    send_wait(1);
    for (int i = 0; i < 8; i++) begin
      read_nib(nib, oe);
      chk($sformatf("rd10_nib%0d", i), 32'(nib), 32'((i / 2) + 1));
      chk($sformatf("rd10_oe%0d", i), 32'(oe), 32'h1);
    end
    ce_high();
    chk("oe_after_ce_rise", 32'(sio_oe), 32'h0);

    // Burst write A5,5A at 0x100 then read back.
    ce_low();
    send_cmd_addr(8'h38, 24'h000100);
    send_nib(4'hA); send_nib(4'h5);
    send_nib(4'h5); send_nib(4'hA);
    chk("oe_in_write", 32'(sio_oe), 32'h0);
    ce_high();
    ce_low();
    send_cmd_addr(8'hEB, 24'h000100);
    send_wait(WAIT_CYC);
    read_byte(b, oe);
    chk("rd100_b0", 32'(b), 32'hA5);
    read_byte(b, oe);
    chk("rd100_b1", 32'(b), 32'h5A);
    ce_high();

    // Partial write: 0x201 preset to 77, then nibbles A,5,C at 0x200.
    write_byte_at(24'h000201, 8'h77);
    ce_low();
    send_cmd_addr(8'h38, 24'h000200);
    send_nib(4'hA); send_nib(4'h5); send_nib(4'hC);
    ce_high();
    ce_low();
    send_cmd_addr(8'hEB, 24'h000200);
    send_wait(WAIT_CYC);
    read_byte(b, oe);
    chk("partial_200", 32'(b), 32'hA5);
    read_byte(b, oe);
    chk("partial_201", 32'(b), 32'h77);
    ce_high();

    // Page boundary: read 0x3FF then the next byte.
    write_byte_at(24'h0003FF, 8'h3C);
    write_byte_at(24'h000400, 8'h4D);
    write_byte_at(24'h000000, 8'hE1);
    ce_low();
    send_cmd_addr(8'hEB, 24'h0003FF);
    send_wait(WAIT_CYC);
    read_byte(b, oe);
    chk("page_b0", 32'(b), 32'h3C);
    read_byte(b, oe);
`ifdef QSPI_PSRAM_PAGE_WRAP_EN
    chk("page_b1_wrap", 32'(b), 32'hE1);
`else
    chk("page_b1_linear", 32'(b), 32'h4D);
`endif
    ce_high();

    // Upper address bits beyond ADR_W are ignored: 0xAB0010 aliases 0x0010.
    ce_low();
    send_cmd_addr(8'hEB, 24'hAB0010);
    send_wait(WAIT_CYC);
    read_byte(b, oe);
    chk("alias_b0", 32'(b), 32'h11);
    ce_high();

    // Device ID read.
    ce_low();
    send_cmd_addr(8'h9F, 24'h123456);
    send_wait(WAIT_CYC);
    read_byte(b, oe);
    chk("id_b0", 32'(b), 32'h0D);
    chk("id_oe", 32'(oe), 32'h1);
    read_byte(b, oe);
    chk("id_b1", 32'(b), 32'h5D);
    read_byte(b, oe);
    chk("id_b2", 32'(b), 32'h0D);
    read_byte(b, oe);
    chk("id_b3", 32'(b), 32'h5D);
    ce_high();

    // Unknown command.
    ce_low();
    send_cmd_addr(8'h5A, 24'h000010);
    send_wait(WAIT_CYC + 4);
    chk("unk_oe", 32'(sio_oe), 32'h0);
    chk("unk_active", 32'(active), 32'h1);
    ce_high();
    chk("unk_active_after", 32'(active), 32'h0);

    // Reset in the middle of a read.
    ce_low();
    send_cmd_addr(8'hEB, 24'h000010);
    send_wait(WAIT_CYC);
    read_byte(b, oe);
    chk("pre_rst_b0", 32'(b), 32'h11);
    chk("pre_rst_oe", 32'(sio_oe), 32'h1);
    rst = 1'b1;
    clks(1);
    rst = 1'b0;
    chk("mid_rst_oe", 32'(sio_oe), 32'h0);
    chk("mid_rst_active", 32'(active), 32'h0);
    for (int i = 0; i < 4; i++) begin
      send_nib(4'hF);
    end
    chk("post_rst_ignore_oe", 32'(sio_oe), 32'h0);
    chk("post_rst_ignore_active", 32'(active), 32'h1);
    ce_high();
    ce_low();
    send_cmd_addr(8'hEB, 24'h000100);
    send_wait(WAIT_CYC);
    read_byte(b, oe);
    chk("post_rst_b0", 32'(b), 32'hA5);
    read_byte(b, oe);
    chk("post_rst_b1", 32'(b), 32'h5A);
    chk("post_rst_oe", 32'(oe), 32'h1);
    ce_high();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qspi_psram_model_q.md
# qspi_psram_model_q

Parametrised QPI PSRAM slave model for simulation tops, the next generation of the team's single-configuration PSRAM model. It oversamples `sck` and `ce_n` on the system clock, decodes quad-wide command, address, wait and data phases, and serves a byte-wide backing array. Memory size, read latency and the device ID are parameters, and burst wrap is a compile option. It sits beside `fpga_top` in sim tops, and the testbench builds the `sio` tristate from `sio_o`/`sio_oe`.

## Interface
- `ADR_W`, 16: byte address width; array holds 2^ADR_W bytes.
- `WAIT_CYC`, 6: `sck` rising edges between the last address nibble and the first read data nibble (legal range 0-15).
- `DEV_ID`, 16'h0D5D: two ID bytes returned by command 0x9F, high byte first, repeating.
- `PAGE_BYTES`, 1024: wrap page size; power of two, at most 2^ADR_W. Used only with the wrap option.
- `clk` in 1: model clock. Must be at least 4x the `sck` frequency.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `sck` in 1: QSPI serial clock from the controller.
- `ce_n` in 1: chip enable, active low.
- `sio_i` in 4: sampled data lines.
- `sio_o` out 4: driven read data.
- `sio_oe` out 1: output enable for `sio_o`.
- `active` out 1: high while a transaction is decoded, i.e. state is not IDLE.
- Backing array is named `ram`, declared [0:2^ADR_W-1] of 8 bits, so `$readmemh` can load it hierarchically.

## Operation
- Synchronisers:
  - `sck` and `ce_n` pass through 2 flops each.
  - A rise is synchronised `sck` high with the previous sample low. A fall is the opposite.
  - `sio_i` is captured in the cycle that detects a rise.
  - Edges are ignored while synchronised `ce_n` is high.
- Nibble order: high nibble first. Command takes 2 nibbles, address 6 nibbles (24 bits, upper bits above ADR_W ignored), and each data byte 2 nibbles.
- States and transitions:
  - IDLE: on a `ce_n` fall, go to CMD.
  - CMD: after 2 rises, decode the command.
    - 0xEB goes to ADDR, then WAIT, then RDATA.
    - 0x38 goes to ADDR, then WDATA.
    - 0x9F goes to ADDR, then WAIT, then IDRD.
    - Any other command goes to IGNORE.
  - ADDR: 6 rises. With WAIT_CYC=0, WAIT is skipped.
  - WAIT: count WAIT_CYC rises.
  - RDATA: drive the next nibble of `ram[addr]` on each fall. Increment `addr` after the low nibble.
  - WDATA: assemble 2 nibbles, then write `ram[addr]` and increment `addr`.
  - IDRD: like RDATA, but the source is DEV_ID bytes, alternating.
  - IGNORE: wait for `ce_n` to rise.
- Any state goes to IDLE in the cycle after synchronised `ce_n` is seen high. At that point `sio_oe` drops, and a partial write byte (one nibble) is discarded. Completed bytes stay written.
- `sio_oe` is 1 only in RDATA and IDRD, from the first fall after the phase is entered.
- Address arithmetic is modulo 2^ADR_W unless the wrap option is compiled in.
- Reset:
  - Sets IDLE, `sio_o`=0, `sio_oe`=0, `active`=0, clears counters and the address register.
  - Mid-transaction reset aborts the transaction.
  - After reset, the model stays in IGNORE until `ce_n` has been seen high once.
  - `ram` contents are never cleared.

## Timing
- Edge detect latency is 2 clk from the pin to the synchronised signal, plus 1 clk to act.
- The first read nibble is driven at the fall that follows the WAIT_CYC-th wait rise (or the last address rise when WAIT_CYC=0). It is valid before the next rise.
- A write byte is committed to `ram` 1 clk after the rise that captured its low nibble.
- `active` asserts 1 clk after the synchronised `ce_n` fall. It deasserts 1 clk after the synchronised rise.
- A `ce_n` rise and an `sck` rise detected in the same clk: the `ce_n` rise wins and the nibble is dropped.

## Configuration
- `QSPI_PSRAM_PAGE_WRAP_EN` defined:
  - The burst address increment wraps within the PAGE_BYTES-aligned page.
  - Upper bits are held and the low log2(PAGE_BYTES) bits increment modulo PAGE_BYTES.
- Not defined: linear increment across pages, wrapping only at 2^ADR_W.

## Test plan
- Preload `ram[0x10..0x13]`=11,22,33,44. Issue 0xEB, addr 0x000010, WAIT_CYC=6, read 4 bytes -> `sio_o` nibbles 1,1,2,2,3,3,4,4, with `sio_oe` high only during data.
- Issue 0x38, addr 0x000100, data A5,5A, then ce_n high, then read back -> `ram[0x100]`=A5 and `ram[0x101]`=5A.
- Write 3 nibbles (A,5,C) at 0x200, then raise ce_n -> `ram[0x200]`=A5 and `ram[0x201]` unchanged.
- Read 2 bytes at 0x3FF with ADR_W=16:
  - With the macro defined -> bytes `ram[0x3FF]`, `ram[0x000]`.
  - Without the macro -> `ram[0x3FF]`, `ram[0x400]`.
- Issue 0x9F with dummy addr, read 4 bytes -> 0D,5D,0D,5D. Issue unknown cmd 0x5A -> `sio_oe` stays 0 and `active` stays high until ce_n rises.
- Assert `rst` for 1 clk mid-read -> next clk `sio_oe`=0 and `active`=0. The next full 0xEB transaction after a ce_n high period returns correct data.
